// File: rtl/cache_ram_bridge_if.sv
// Cache-to-memory bridge bus bundle.
// Holds the per-word cache access signals and the req/ack main-memory port.
//   master : the bridge side (drives ram_ready, block_from_ram, mem_*; samples the rest)
//   slave  : the environment side (cache plus memory model)
// Signals:
//   ram_en, ram_write, ram_addr, dc_data_wb   cache -> bridge word access request
//   ram_ready, block_from_ram                 bridge -> cache completion and read block
//   mem_req, mem_we, mem_addr, mem_wdata      bridge -> memory request
//   mem_ack, mem_rdata                        memory -> bridge completion and read data
interface cache_ram_bridge_if #(
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH   = 30,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BLOCK_SIZE   = 1 << OFFSET_WIDTH,
    parameter int unsigned BLOCK_WIDTH  = DATA_WIDTH * BLOCK_SIZE
) ();
    logic                   ram_en;
    logic                   ram_write;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [BLOCK_WIDTH-1:0] dc_data_wb;
    logic                   ram_ready;
    logic [BLOCK_WIDTH-1:0] block_from_ram;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic                   mem_ack;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    modport master (
        input  ram_en, ram_write, ram_addr, dc_data_wb, mem_ack, mem_rdata,
        output ram_ready, block_from_ram, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output ram_en, ram_write, ram_addr, dc_data_wb, mem_ack, mem_rdata,
        input  ram_ready, block_from_ram, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ram_bridge.sv
// Bridge between the cache top level and a word-wide req/ack main memory port.
// Each cache word access becomes one memory transaction; read words are stored into the
// block_from_ram slot picked by the address offset, and a one-cycle ram_ready pulse marks
// each completed word.
// Ports:
//   clk  : single clock, all logic on posedge
//   rst  : synchronous active-high reset, aborts any transaction
//   bus  : cache_ram_bridge_if.master (cache request/ready, block output, memory req/ack)
module cache_ram_bridge #(
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH   = 30,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BLOCK_SIZE   = 1 << OFFSET_WIDTH,
    parameter int unsigned BLOCK_WIDTH  = DATA_WIDTH * BLOCK_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    cache_ram_bridge_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                                r_state;
    logic                                  r_mem_req;
    logic                                  r_mem_we;
    logic [ADDR_WIDTH-1:0]                 r_mem_addr;
    logic [DATA_WIDTH-1:0]                 r_mem_wdata;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_block;

    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] w_wb_words;
    logic [OFFSET_WIDTH-1:0]               w_slot_in;
    logic [OFFSET_WIDTH-1:0]               w_slot_req;

    assign w_wb_words = bus.dc_data_wb;
    assign w_slot_in  = bus.ram_addr[OFFSET_WIDTH-1:0];
    // Slot for the returning read comes from the latched address, not the live input.
    assign w_slot_req = r_mem_addr[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_block     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.ram_en) begin
                        r_mem_we    <= bus.ram_write;
                        r_mem_addr  <= bus.ram_addr;
                        r_mem_wdata <= w_wb_words[w_slot_in];
                        r_mem_req   <= 1'b1;
                        r_state     <= StReq;
                    end
                end
                StReq: begin
                    // Request and its payload stay frozen until the ack arrives.
                    if (bus.mem_ack) begin
                        if (!r_mem_we) begin
                            r_block[w_slot_req] <= bus.mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    // The cache advances its word counter on this edge, so the next
                    // address is sampled only once back in idle.
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // A cache that has left its miss state by the done cycle gets no ready pulse.
    assign bus.ram_ready      = (r_state == StDone) && bus.ram_en;
    assign bus.block_from_ram = r_block;
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_we         = r_mem_we;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_cache_ram_bridge.sv
// Directed self-checking bench for cache_ram_bridge.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cache_ram_bridge;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cache_ram_bridge_if bus ();

    cache_ram_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0][31:0] exp_blk;
    logic [7:0][31:0] wb_blk;
    int               n_ready;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        n_ready        = 0;
        rst            = 1'b1;
        bus.ram_en     = 1'b0;
        bus.ram_write  = 1'b0;
        bus.ram_addr   = '0;
        bus.dc_data_wb = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_ready", bus.ram_ready, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 30'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_block", bus.block_from_ram, 256'h0);

        // Single read, ack in first REQ cycle, slot 5
        bus.ram_en   = 1'b1;
        bus.ram_addr = 30'h0000_1235;
        tick();
        check("rd_req", bus.mem_req, 1'b1);
        check("rd_addr", bus.mem_addr, 30'h0000_1235);
        check("rd_we", bus.mem_we, 1'b0);
        check("rd_ready_early", bus.ram_ready, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0;
        check("rd_req_drop", bus.mem_req, 1'b0);
        check("rd_ready", bus.ram_ready, 1'b1);
        check("rd_block", bus.block_from_ram, {64'h0, 32'hDEAD_BEEF, 160'h0});
        bus.ram_en = 1'b0;
        tick();
        check("rd_ready_single", bus.ram_ready, 1'b0);
        check("rd_idle_req", bus.mem_req, 1'b0);

        // 8-word read burst, ack latency 4
        for (int i = 0; i < 8; i++) begin
            exp_blk[i] = 32'hA000_0000 + 32'(i) * 32'h0101_1111;
        end
        bus.ram_en    = 1'b1;
        bus.ram_write = 1'b0;
        bus.ram_addr  = 30'h100;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bu_req", bus.mem_req, 1'b1);
            check("bu_addr", bus.mem_addr, 30'h100 + 30'(i));
            for (int k = 0; k < 3; k++) begin
                tick();
                check("bu_hold_req", bus.mem_req, 1'b1);
                check("bu_hold_addr", bus.mem_addr, 30'h100 + 30'(i));
                check("bu_hold_ready", bus.ram_ready, 1'b0);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = exp_blk[i];
            tick();
            bus.mem_ack = 1'b0;
            if (bus.ram_ready === 1'b1) n_ready++;
            check("bu_ready", bus.ram_ready, 1'b1);
            if (i == 7) bus.ram_en = 1'b0;
            else bus.ram_addr = 30'h100 + 30'(i + 1);
            tick();
            check("bu_ready_gap", bus.ram_ready, 1'b0);
            check("bu_idle_req", bus.mem_req, 1'b0);
        end
        check("bu_pulses", 32'(n_ready), 32'd8);
        check("bu_block", bus.block_from_ram, exp_blk);
        tick();
        check("bu_no_reissue", bus.mem_req, 1'b0);

        // Write-back, offset 3
        for (int i = 0; i < 8; i++) wb_blk[i] = 32'hBAD0_0000 + 32'(i);
        wb_blk[3]      = 32'h1234_5678;
        bus.dc_data_wb = wb_blk;
        bus.ram_en     = 1'b1;
        bus.ram_write  = 1'b1;
        bus.ram_addr   = 30'h103;
        tick();
        check("wb_req", bus.mem_req, 1'b1);
        check("wb_we", bus.mem_we, 1'b1);
        check("wb_addr", bus.mem_addr, 30'h103);
        check("wb_wdata", bus.mem_wdata, 32'h1234_5678);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack = 1'b0;
        check("wb_ready", bus.ram_ready, 1'b1);
        check("wb_block_kept", bus.block_from_ram, exp_blk);
        bus.ram_en    = 1'b0;
        bus.ram_write = 1'b0;
        tick();
        check("wb_idle_ready", bus.ram_ready, 1'b0);

        // ram_en dropped during REQ, ack after 5 cycles
        bus.ram_en   = 1'b1;
        bus.ram_addr = 30'h200;
        tick();
        check("ab_req", bus.mem_req, 1'b1);
        bus.ram_en   = 1'b0;
        bus.ram_addr = 30'h3FF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ab_hold_req", bus.mem_req, 1'b1);
            check("ab_hold_addr", bus.mem_addr, 30'h200);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ack = 1'b0;
        check("ab_req_drop", bus.mem_req, 1'b0);
        check("ab_no_ready", bus.ram_ready, 1'b0);
        exp_blk[0] = 32'hCAFE_F00D;
        check("ab_block", bus.block_from_ram, exp_blk);
        tick();
        check("ab_idle_ready", bus.ram_ready, 1'b0);
        tick();
        check("ab_idle_req", bus.mem_req, 1'b0);

        // Reset while in REQ, then a late ack
        bus.ram_en   = 1'b1;
        bus.ram_addr = 30'h305;
        tick();
        check("rr_req", bus.mem_req, 1'b1);
        rst        = 1'b1;
        bus.ram_en = 1'b0;
        tick();
        check("rr_req_drop", bus.mem_req, 1'b0);
        check("rr_block", bus.block_from_ram, 256'h0);
        check("rr_addr", bus.mem_addr, 30'h0);
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        tick();
        bus.mem_ack = 1'b0;
        check("rr_late_ready", bus.ram_ready, 1'b0);
        check("rr_late_block", bus.block_from_ram, 256'h0);
        check("rr_late_req", bus.mem_req, 1'b0);
        tick();
        check("rr_idle_ready", bus.ram_ready, 1'b0);

        // Spurious ack in IDLE
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_ack = 1'b0;
        check("sp_ready", bus.ram_ready, 1'b0);
        check("sp_block", bus.block_from_ram, 256'h0);
        check("sp_req", bus.mem_req, 1'b0);
        tick();
        check("sp_ready_after", bus.ram_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
